// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - op codes, FSM encodings and helpers for the mul/div sequencer
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int HILO_WD = 66;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Magnitude of a 32-bit operand; unsigned ops pass the value through untouched.
    // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// rtl/muldiv_ctrl_div_step.sv - one combinational restoring-divide step
module div_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic        unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is never set;
    // shift the next dividend bit in and subtract the divisor when it fits.
    always_comb begin
        shifted        = {rem_in[31:0], quo_in[31]};
        diff           = shifted - {1'b0, divisor};
        fits           = (shifted >= {1'b0, divisor});
        rem_out        = fits ? diff : shifted;
        quo_out        = {quo_in[30:0], fits};
        unused_rem_msb = rem_in[32];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO write bus (option: MULDIV_FAST_MUL_EN)
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int ITER_CNT = 32,
    parameter int CNT_W    = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    input  logic               cancel,
    output logic               stallreq,
    output logic               busy,
    output logic [HILO_WD-1:0] hilo_bus
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             q_neg;
    logic             r_neg;
    logic [31:0]      mcand;
    logic [31:0]      divisor;
    logic [63:0]      prod;
    logic [32:0]      rem;
    logic [31:0]      quo;

    logic             signed_op;
    logic             div_op;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic             accept;
    logic             last_iter;
    logic [32:0]      mul_sum;
    logic [32:0]      rem_nxt;
    logic [31:0]      quo_nxt;
    logic [63:0]      prod_fix;
    logic [31:0]      quo_fix;
    logic [31:0]      rem_fix;
    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             unused_rem_msb;

    // Operand decode, accept qualification and the inline shift-add multiply step.
    always_comb begin
        signed_op = ~op[0];
        div_op    = op[1];
        a_mag     = mag32(src_a, signed_op);
        b_mag     = mag32(src_b, signed_op);
        accept    = start && !cancel && (state != ST_BUSY);
        last_iter = (cnt == CNT_W'(ITER_CNT - 1));
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    end

    div_step u_div_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // Sequencer: cancel wins over everything; start is only taken in IDLE or DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            mcand   <= '0;
            divisor <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
        end else if (cancel) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (is_div) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                    end else begin
                        prod <= {mul_sum, prod[31:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        is_div  <= div_op;
                        cnt     <= '0;
                        mcand   <= a_mag;
                        divisor <= b_mag;
                        q_neg   <= signed_op & (src_a[31] ^ src_b[31]);
                        r_neg   <= signed_op & src_a[31];
                        rem     <= '0;
                        quo     <= a_mag;
                        prod    <= {32'd0, b_mag};
                        state   <= ST_BUSY;
                        if (div_op && (src_b == 32'd0)) begin
                            // Divide by zero: preload the defined result, skip iterating.
                            rem   <= {1'b0, src_a};
                            quo   <= 32'hFFFF_FFFF;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!div_op) begin
                            prod  <= {32'd0, a_mag} * {32'd0, b_mag};
                            state <= ST_DONE;
                        end
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sign correction and the HI/LO write bus, live only during DONE.
    always_comb begin
        prod_fix       = q_neg ? (64'd0 - prod) : prod;
        quo_fix        = q_neg ? (32'd0 - quo) : quo;
        rem_fix        = r_neg ? (32'd0 - rem[31:0]) : rem[31:0];
        hi_res         = is_div ? rem_fix : prod_fix[63:32];
        lo_res         = is_div ? quo_fix : prod_fix[31:0];
        hilo_bus       = (state == ST_DONE) ? {2'b11, hi_res, lo_res} : '0;
        busy           = (state == ST_BUSY);
        stallreq       = accept || busy;
        unused_rem_msb = rem[32];
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed table-driven bench for muldiv_ctrl
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int BOUND = 100;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        busy;
    logic [65:0] hilo_bus;

    int n_tests;
    int n_fail;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    muldiv_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stallreq (stallreq),
        .busy     (busy),
        .hilo_bus (hilo_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int k);
        while (!hilo_bus[65] && k < BOUND) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    task automatic watch_no_write(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (hilo_bus[65] || hilo_bus[64]) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        int  k;
        logic stall_ok;

        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{"divu_100_7",    MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[1]  = '{"div_m7_2",      MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[2]  = '{"div_7_m2",      MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[3]  = '{"mult_m3_5",     MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT};
        vecs[4]  = '{"multu_max_2",   MD_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MUL_LAT};
        vecs[5]  = '{"div_by_zero",   MD_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{"div_min_m1",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[7]  = '{"mult_6_7",      MD_MULT,  32'd6,         32'd7,         32'd0,         32'd42,        MUL_LAT};
        vecs[8]  = '{"divu_max_1",    MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33};
        vecs[9]  = '{"multu_max_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[10] = '{"divu_5_10",     MD_DIVU,  32'd5,         32'd10,        32'd5,         32'd0,         33};

        resetn = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hilo", {62'd0, hilo_bus[1:0]} | {32'd0, hilo_bus[65:34]}, 64'd0);
        chk("reset_busy", {62'd0, busy, stallreq}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            drive(vecs[v].op, vecs[v].a, vecs[v].b);
            #1;
            chk({vecs[v].name, "_stall_T"}, {63'd0, stallreq}, 64'd1);
            @(negedge clk);
            start = 1'b0;
            #1;
            k = 1;
            stall_ok = 1'b1;
            while (!hilo_bus[65] && k < BOUND) begin
                if (!stallreq) stall_ok = 1'b0;
                @(negedge clk);
                #1;
                k++;
            end
            chk({vecs[v].name, "_lat"}, 64'(k), 64'(vecs[v].lat));
            chk({vecs[v].name, "_we"}, {62'd0, hilo_bus[65:64]}, 64'd3);
            chk({vecs[v].name, "_hilo"}, hilo_bus[63:0], {vecs[v].hi, vecs[v].lo});
            chk({vecs[v].name, "_stall_hold"}, {63'd0, stall_ok}, 64'd1);
            chk({vecs[v].name, "_stall_done"}, {63'd0, stallreq}, 64'd0);
            @(negedge clk);
            #1;
            chk({vecs[v].name, "_after"}, {63'd0, hilo_bus[65]}, 64'd0);
        end

        // cancel at T+10 of a DIVU: back to IDLE at T+11, nothing ever written
        @(negedge clk);
        drive(MD_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_idle", {62'd0, busy, stallreq}, 64'd0);
        watch_no_write("cancel_no_write", 40);

        // start together with cancel is not accepted
        @(negedge clk);
        drive(MD_DIVU, 32'd9, 32'd3);
        cancel = 1'b1;
        #1;
        chk("start_cancel_stall", {63'd0, stallreq}, 64'd0);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        chk("start_cancel_busy", {63'd0, busy}, 64'd0);
        watch_no_write("start_cancel_no_write", 40);

        // start during BUSY is ignored
        @(negedge clk);
        drive(MD_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive(MD_MULTU, 32'd3, 32'd3);
        @(negedge clk);
        start = 1'b0;
        #1;
        k = 6;
        wait_done(k);
        chk("busy_start_lat", 64'(k), 64'd33);
        chk("busy_start_hilo", hilo_bus[63:0], {32'd2, 32'd14});

        // start in DONE: current result written, next op runs full length
        @(negedge clk);
        drive(MD_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        #1;
        k = 1;
        wait_done(k);
        drive(MD_DIVU, 32'd50, 32'd5);
        #1;
        chk("done_start_stall", {63'd0, stallreq}, 64'd1);
        chk("done_start_old", hilo_bus[63:0], {32'd2, 32'd14});
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_start_busy", {63'd0, busy}, 64'd1);
        k = 1;
        wait_done(k);
        chk("done_start_lat", 64'(k), 64'd33);
        chk("done_start_new", hilo_bus[63:0], {32'd0, 32'd10});

        // async reset mid-BUSY clears outputs without a clock edge
        @(negedge clk);
        drive(MD_DIV, 32'd77, 32'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_busy", {62'd0, busy, stallreq}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // async reset during DONE drops the write bus immediately
        @(negedge clk);
        drive(MD_DIV, 32'h1234, 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("areset_pre_done", {62'd0, hilo_bus[65:64]}, 64'd3);
        resetn = 1'b0;
        #1;
        chk("areset_done_hilo", hilo_bus[63:0] | {62'd0, hilo_bus[65:64]}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        watch_no_write("areset_no_write", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
